te_branch_map: RTL and testbench
================================

Name: te_branch_map

Overview:
- Sits directly downstream of the multiple-retirement block and upstream of the trace-encoder packet emitter.
- Consumes one instruction block per cycle, lane 0 of the block bus.
- Accumulates a branch map of up to MAX_BRANCHES taken/not-taken bits.
- Emits one registered record per valid/ready handshake when:
  - the map fills;
  - a non-inferable discontinuity arrives;
  - a flush is requested.

Parameters:
- MAX_BRANCHES, 31, map capacity in bits; legal range 1..31.
- CNT_W, $clog2(MAX_BRANCHES+1), width of the branch counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset: asynchronous, active-low
- valid_i  in  1  input block valid
- itype_i  in  mure_pkg::ITYPE_LEN  block type
- iaddr_i  in  mure_pkg::XLEN  block address
- in_ready_o  out  1  block can be accepted this cycle
- flush_i  in  1  force emission of the pending map
- rec_valid_o  out  1  record valid
- rec_ready_i  in  1  downstream accepts the record
- rec_kind_o  out  2  record kind: 0 FULL, 1 DISC, 2 FLUSH
- rec_map_o  out  MAX_BRANCHES  branch bits; bit i is the i-th branch; 1 = not taken, 0 = taken
- rec_count_o  out  CNT_W  number of valid map bits
- rec_itype_o  out  mure_pkg::ITYPE_LEN  itype of the DISC block; 0 for other kinds
- rec_addr_o  out  mure_pkg::XLEN  iaddr of the DISC block, or of the last branch for FULL/FLUSH
- overflow_o  out  1  sticky: a block arrived while in_ready_o was low

Behaviour:
- Reset state: all outputs 0 except in_ready_o = 1; map, count and last-address registers cleared. Reset mid-record discards the record with no further handshake.
- itype classes:
  - 4 = not-taken branch.
  - 5 = taken branch.
  - 1, 2, 3 and >= 6 = DISC.
  - 0 = plain; ignored.
- in_ready_o = !rec_valid_o || rec_ready_i, combinational. A block is accepted when valid_i && in_ready_o.
- valid_i && !in_ready_o: the block is dropped and overflow_o sets, staying set until reset.
- Two-state FSM on count:
  - EMPTY (count == 0), ACCUM (count > 0).
  - A branch in EMPTY moves to ACCUM.
  - Any emission returns to EMPTY.
- Accepted branch:
  - map[count] <= (itype == 4); count <= count + 1; last_addr <= iaddr_i.
  - If count + 1 == MAX_BRANCHES, a FULL record is loaded instead: map including the new bit, count = MAX_BRANCHES, addr = iaddr_i. Map and count then clear.
- Accepted DISC block:
  - Loads a DISC record with the current map/count (count may be 0), itype_i and iaddr_i; map and count clear.
  - A DISC record is emitted even from EMPTY.
- flush_i:
  - Loads a FLUSH record (map, count, last_addr) only when the post-input count > 0 and in_ready_o is high. Otherwise it is ignored; no pending flag is kept.
  - Same cycle as an accepted branch: the branch is recorded first and the flush then emits the map including it, unless the branch already produced FULL, which absorbs the flush.
  - Same cycle as an accepted DISC: DISC wins and the flush is absorbed; exactly one record per cycle.
- Record register:
  - Loads on the clock edge after the triggering input, so latency is 1 cycle.
  - Holds while rec_valid_o && !rec_ready_i.
  - Back-to-back emission (load in the same cycle as acceptance) sustains 1 record/cycle.
- Unused map bits at positions >= rec_count_o are 0.

Decomposition:
- mure_pkg additions:
  - enum rec_kind_e {FULL, DISC, FLUSH}.
  - struct bmap_rec_s {kind, map, count, itype, addr}.
  - itype constants: ITYPE_NT_BRANCH = 4, ITYPE_TK_BRANCH = 5.
- No sub-module is needed. The record register is an inline one-entry valid/ready output stage; fifo_v3 is not used.

Test Plan:
- Reset, then 3 blocks with itype 4, 5, 4, then one itype 3 at iaddr 0x8000_0100, with rec_ready_i = 1 -> one DISC record: map = 0b101, count = 3, itype = 3, addr = 0x8000_0100.
- 31 consecutive itype-5 blocks with MAX_BRANCHES = 31 -> FULL record one cycle after the 31st: map = 0, count = 31, addr of the 31st block; the next branch starts a fresh map at bit 0.
- 2 branches (itype 4 then 5), then flush_i alone -> FLUSH record map = 0b01, count = 2. flush_i asserted again with count 0 -> no record.
- rec_ready_i held 0 while a DISC record is pending and another DISC block arrives -> in_ready_o = 0, block dropped, overflow_o = 1 and sticky; the pending record stays stable until rec_ready_i = 1.
- Same cycle: itype-5 branch and flush_i with count = 1 -> single FLUSH record, count = 2, map = 0b01. Same cycle: itype-1 block and flush_i -> single DISC record.
- Assert rst_ni low while rec_valid_o = 1 -> rec_valid_o = 0, overflow_o = 0, in_ready_o = 1 asynchronously; the first record after reset reflects only post-reset branches.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared trace-encoder types: instruction classes and the branch-map record.
package mure_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ITYPE_LEN  = 3;
  localparam int unsigned BMAP_MAX   = 31;
  localparam int unsigned BMAP_CNT_W = 5;

  localparam logic [ITYPE_LEN-1:0] ITYPE_PLAIN     = 3'd0;
  localparam logic [ITYPE_LEN-1:0] ITYPE_NT_BRANCH = 3'd4;
  localparam logic [ITYPE_LEN-1:0] ITYPE_TK_BRANCH = 3'd5;

  typedef enum logic [1:0] {
    FULL  = 2'd0,
    DISC  = 2'd1,
    FLUSH = 2'd2
  } rec_kind_e;

  typedef struct packed {
    rec_kind_e                 kind;
    logic [BMAP_MAX-1:0]       map;
    logic [BMAP_CNT_W-1:0]     count;
    logic [ITYPE_LEN-1:0]      itype;
    logic [XLEN-1:0]           addr;
  } bmap_rec_s;

  function automatic logic is_branch(input logic [ITYPE_LEN-1:0] it);
    return (it == ITYPE_NT_BRANCH) || (it == ITYPE_TK_BRANCH);
  endfunction

  function automatic logic is_disc(input logic [ITYPE_LEN-1:0] it);
    return (it != ITYPE_PLAIN) && !is_branch(it);
  endfunction

endpackage

// File: rtl/te_branch_map.sv
// Branch-map accumulator: packs taken/not-taken bits and emits FULL, DISC or
// FLUSH records through a one-entry valid/ready output register.
module te_branch_map
  import mure_pkg::*;
#(
  parameter int unsigned MAX_BRANCHES = 31,
  parameter int unsigned CNT_W        = $clog2(MAX_BRANCHES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  input  logic [ITYPE_LEN-1:0]    itype_i,
  input  logic [XLEN-1:0]         iaddr_i,
  output logic                    in_ready_o,
  input  logic                    flush_i,
  output logic                    rec_valid_o,
  input  logic                    rec_ready_i,
  output logic [1:0]              rec_kind_o,
  output logic [MAX_BRANCHES-1:0] rec_map_o,
  output logic [CNT_W-1:0]        rec_count_o,
  output logic [ITYPE_LEN-1:0]    rec_itype_o,
  output logic [XLEN-1:0]         rec_addr_o,
  output logic                    overflow_o
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [MAX_BRANCHES-1:0] map_q, map_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]         last_addr_q, last_addr_d;
  logic                    overflow_q;

  logic                    vld_p1;
  bmap_rec_s               rec_p1;

  logic                    in_ready;
  logic                    accept;
  logic                    br_acc;
  logic                    load;
  bmap_rec_s               rec_d;

  assign in_ready = !vld_p1 || rec_ready_i;
  assign accept   = valid_i && in_ready;
  assign br_acc   = accept && is_branch(itype_i);

  always_comb begin
    map_d       = map_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    load        = 1'b0;
    rec_d       = '0;

    if (br_acc) begin
      for (int i = 0; i < MAX_BRANCHES; i++) begin
        if (CNT_W'(i) == cnt_q) map_d[i] = (itype_i == ITYPE_NT_BRANCH);
      end
      cnt_d       = cnt_q + CNT_W'(1);
      last_addr_d = iaddr_i;
      if (cnt_d == CNT_W'(MAX_BRANCHES)) begin
        load        = 1'b1;
        rec_d.kind  = FULL;
        rec_d.map   = BMAP_MAX'(map_d);
        rec_d.count = BMAP_CNT_W'(cnt_d);
        rec_d.addr  = iaddr_i;
        map_d       = '0;
        cnt_d       = '0;
      end
    end else if (accept && is_disc(itype_i)) begin
      load        = 1'b1;
      rec_d.kind  = DISC;
      rec_d.map   = BMAP_MAX'(map_q);
      rec_d.count = BMAP_CNT_W'(cnt_q);
      rec_d.itype = itype_i;
      rec_d.addr  = iaddr_i;
      map_d       = '0;
      cnt_d       = '0;
    end

    // A flush folds in any branch taken this cycle; FULL or DISC absorb it.
    if (flush_i && in_ready && !load && ((state_q == S_ACCUM) || br_acc)) begin
      load        = 1'b1;
      rec_d.kind  = FLUSH;
      rec_d.map   = BMAP_MAX'(map_d);
      rec_d.count = BMAP_CNT_W'(cnt_d);
      rec_d.addr  = last_addr_d;
      map_d       = '0;
      cnt_d       = '0;
    end

    state_d = (cnt_d != '0) ? S_ACCUM : S_EMPTY;
  end

  // Stage p1: record register, loads only when the slot is free or draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_EMPTY;
      map_q       <= '0;
      cnt_q       <= '0;
      last_addr_q <= '0;
      overflow_q  <= 1'b0;
      vld_p1      <= 1'b0;
      rec_p1      <= '0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      if (valid_i && !in_ready) overflow_q <= 1'b1;
      if (in_ready) begin
        vld_p1 <= load;
        if (load) rec_p1 <= rec_d;
      end
    end
  end

  assign in_ready_o  = in_ready;
  assign rec_valid_o = vld_p1;
  assign rec_kind_o  = rec_p1.kind;
  assign rec_map_o   = rec_p1.map[MAX_BRANCHES-1:0];
  assign rec_count_o = rec_p1.count[CNT_W-1:0];
  assign rec_itype_o = rec_p1.itype;
  assign rec_addr_o  = rec_p1.addr;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_te_branch_map.sv
// Directed bench for te_branch_map with a queue-based record scoreboard.
module tb_te_branch_map;
  import mure_pkg::*;

  localparam int unsigned MAXB = 31;
  localparam int unsigned CW   = $clog2(MAXB + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            valid_i = 1'b0;
  logic [2:0]      itype_i = '0;
  logic [31:0]     iaddr_i = '0;
  logic            in_ready_o;
  logic            flush_i = 1'b0;
  logic            rec_valid_o;
  logic            rec_ready_i = 1'b1;
  logic [1:0]      rec_kind_o;
  logic [MAXB-1:0] rec_map_o;
  logic [CW-1:0]   rec_count_o;
  logic [2:0]      rec_itype_o;
  logic [31:0]     rec_addr_o;
  logic            overflow_o;

  te_branch_map #(.MAX_BRANCHES(MAXB)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .itype_i     (itype_i),
    .iaddr_i     (iaddr_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .rec_valid_o (rec_valid_o),
    .rec_ready_i (rec_ready_i),
    .rec_kind_o  (rec_kind_o),
    .rec_map_o   (rec_map_o),
    .rec_count_o (rec_count_o),
    .rec_itype_o (rec_itype_o),
    .rec_addr_o  (rec_addr_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  kind;
    logic [30:0] map;
    logic [4:0]  count;
    logic [2:0]  itype;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  task automatic expect_rec(input logic [1:0] k, input logic [30:0] m, input logic [4:0] c,
                            input logic [2:0] it, input logic [31:0] a);
    exp_t e;
    e.kind = k; e.map = m; e.count = c; e.itype = it; e.addr = a;
    q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic send(input logic [2:0] it, input logic [31:0] a, input logic fl);
    valid_i = 1'b1; itype_i = it; iaddr_i = a; flush_i = fl;
    @(posedge clk_i); #1;
    valid_i = 1'b0; itype_i = '0; flush_i = 1'b0;
  endtask

  task automatic flush_only();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Monitor: a handshake is imminent whenever valid and ready are both high.
  always @(negedge clk_i) begin
    if (rst_ni && rec_valid_o && rec_ready_i) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL rec_unexpected: got kind %0d count %0d addr 0x%0h, required no record",
                 rec_kind_o, rec_count_o, rec_addr_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rec_kind",  64'(rec_kind_o),  64'(e.kind));
        chk("rec_map",   64'(rec_map_o),   64'(e.map));
        chk("rec_count", 64'(rec_count_o), 64'(e.count));
        chk("rec_itype", 64'(rec_itype_o), 64'(e.itype));
        chk("rec_addr",  64'(rec_addr_o),  64'(e.addr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rec_valid", 64'(rec_valid_o), 64'd0);
    chk("rst_in_ready",  64'(in_ready_o),  64'd1);
    chk("rst_overflow",  64'(overflow_o),  64'd0);
    chk("rst_rec_flds",  {rec_kind_o, rec_count_o, rec_itype_o, rec_addr_o}, 64'd0);
    chk("rst_rec_map",   64'(rec_map_o),   64'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Three branches then a discontinuity.
    send(3'd4, 32'h8000_00f0, 1'b0);
    send(3'd5, 32'h8000_00f4, 1'b0);
    send(3'd4, 32'h8000_00f8, 1'b0);
    expect_rec(2'd1, 31'b101, 5'd3, 3'd3, 32'h8000_0100);
    send(3'd3, 32'h8000_0100, 1'b0);
    send(3'd0, 32'h8000_0104, 1'b0);

    // Map fill with taken branches; the next branch starts at bit 0.
    for (int i = 0; i < 31; i++) begin
      if (i == 30) expect_rec(2'd0, 31'd0, 5'd31, 3'd0, 32'h1000 + 32'(4 * i));
      send(3'd5, 32'h1000 + 32'(4 * i), 1'b0);
    end
    send(3'd4, 32'h2000, 1'b0);
    expect_rec(2'd2, 31'b1, 5'd1, 3'd0, 32'h2000);
    flush_only();

    // Flush of two branches, then a flush with nothing pending.
    send(3'd4, 32'h3000, 1'b0);
    send(3'd5, 32'h3004, 1'b0);
    expect_rec(2'd2, 31'b01, 5'd2, 3'd0, 32'h3004);
    flush_only();
    flush_only();
    idle(2);
    chk("empty_flush_no_rec", 64'(rec_valid_o), 64'd0);

    // Backpressure: pending record holds, second block dropped.
    rec_ready_i = 1'b0;
    expect_rec(2'd1, 31'd0, 5'd0, 3'd2, 32'h4000);
    send(3'd2, 32'h4000, 1'b0);
    chk("bp_rec_valid", 64'(rec_valid_o), 64'd1);
    chk("bp_in_ready",  64'(in_ready_o),  64'd0);
    send(3'd6, 32'h4010, 1'b0);
    chk("bp_overflow",  64'(overflow_o),  64'd1);
    idle(2);
    chk("bp_hold_addr",  64'(rec_addr_o),  64'h4000);
    chk("bp_hold_itype", 64'(rec_itype_o), 64'd2);
    chk("bp_hold_valid", 64'(rec_valid_o), 64'd1);
    rec_ready_i = 1'b1;
    idle(1);
    chk("bp_drained",        64'(rec_valid_o), 64'd0);
    chk("overflow_sticky",   64'(overflow_o),  64'd1);

    // Same-cycle branch + flush, and DISC + flush.
    send(3'd4, 32'h5000, 1'b0);
    expect_rec(2'd2, 31'b01, 5'd2, 3'd0, 32'h5004);
    send(3'd5, 32'h5004, 1'b1);
    send(3'd4, 32'h5100, 1'b0);
    expect_rec(2'd1, 31'b1, 5'd1, 3'd1, 32'h5200);
    send(3'd1, 32'h5200, 1'b1);
    idle(1);
    chk("disc_flush_single", 64'(rec_valid_o), 64'd0);

    // FULL absorbs a same-cycle flush.
    for (int i = 0; i < 31; i++) begin
      if (i == 30) expect_rec(2'd0, 31'h7fff_ffff, 5'd31, 3'd0, 32'h5800 + 32'(4 * i));
      send(3'd4, 32'h5800 + 32'(4 * i), (i == 30));
    end
    idle(1);
    chk("full_flush_single", 64'(rec_valid_o), 64'd0);

    // Asynchronous reset while a record is pending (record discarded).
    rec_ready_i = 1'b0;
    send(3'd7, 32'h6100, 1'b0);
    chk("prerst_valid", 64'(rec_valid_o), 64'd1);
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_rec_valid", 64'(rec_valid_o), 64'd0);
    chk("arst_overflow",  64'(overflow_o),  64'd0);
    chk("arst_in_ready",  64'(in_ready_o),  64'd1);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    rec_ready_i = 1'b1;

    // Stale branches must not survive a reset.
    send(3'd4, 32'h6200, 1'b0);
    send(3'd4, 32'h6204, 1'b0);
    #3 rst_ni = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    expect_rec(2'd2, 31'd0, 5'd1, 3'd0, 32'h7000);
    send(3'd5, 32'h7000, 1'b1);

    idle(3);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
